// File: rtl/data_cache.sv
// data_cache: direct-mapped, one-word-line, write-through, no-write-allocate
// data cache between the datapath load/store port and a req/ack memory.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   Address             word address from the datapath
//   WriteData           store data
//   MemRead, MemWrite   level requests, held by the core while Stall=1
//   ReadData            load data (combinational on hits and fill bypass)
//   Stall               core must hold its request this cycle
//   mem_req, mem_we     backing-memory request and direction
//   mem_addr, mem_wdata request address/data, stable while mem_req=1
//   mem_ack, mem_rdata  one-cycle completion pulse and read data
//   hit_count           saturating count of loads served from the cache
//   miss_count          saturating count of load misses
module data_cache #(
  parameter int NBITS  = 8,
  parameter int NLINES = 4,
  parameter int CNTW   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-3:0] Address,
  input  logic [NBITS-1:0] WriteData,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [NBITS-1:0] ReadData,
  output logic             Stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [NBITS-3:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [NBITS-1:0] mem_rdata,
  output logic [CNTW-1:0]  hit_count,
  output logic [CNTW-1:0]  miss_count
);

  localparam int IDX = $clog2(NLINES);
  localparam int TAG = NBITS - 2 - IDX;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

  state_t state_q, state_d;

  logic [NBITS-3:0] addr_q, addr_d;
  logic [NBITS-1:0] wdata_q, wdata_d;
  logic             we_q, we_d;

  logic [NLINES-1:0] valid_q;
  logic [TAG-1:0]    tag_q  [NLINES];
  logic [NBITS-1:0]  data_q [NLINES];

  logic [CNTW-1:0] hit_q, miss_q;

  logic [IDX-1:0] idx;
  logic [TAG-1:0] tag;
  logic [IDX-1:0] m_idx;
  logic [TAG-1:0] m_tag;
  logic           hit;
  logic           fill;
  logic           wupd;
  logic           hit_inc;
  logic           miss_inc;

  assign idx   = Address[IDX-1:0];
  assign tag   = Address[NBITS-3:IDX];
  // Pending transaction's line comes from the latched address.
  assign m_idx = addr_q[IDX-1:0];
  assign m_tag = addr_q[NBITS-3:IDX];

  assign hit = MemRead & valid_q[idx] & (tag_q[idx] == tag);

  assign mem_req    = (state_q != IDLE);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    Stall    = 1'b0;
    ReadData = '0;
    fill     = 1'b0;
    wupd     = 1'b0;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemWrite) begin
          addr_d  = Address;
          wdata_d = WriteData;
          we_d    = 1'b1;
          Stall   = 1'b1;
          state_d = WRITE;
        end else if (MemRead) begin
          if (hit) begin
            ReadData = data_q[idx];
            hit_inc  = 1'b1;
          end else begin
            addr_d   = Address;
            we_d     = 1'b0;
            Stall    = 1'b1;
            miss_inc = 1'b1;
            state_d  = FILL;
          end
        end
      end
      FILL: begin
        Stall = ~mem_ack;
        if (mem_ack) begin
          ReadData = mem_rdata;
          fill     = 1'b1;
          state_d  = IDLE;
        end
      end
      WRITE: begin
        Stall = ~mem_ack;
        if (mem_ack) begin
          // Write-update only a resident line; never allocate.
          wupd    = valid_q[m_idx] & (tag_q[m_idx] == m_tag);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      valid_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      if (fill) valid_q[m_idx] <= 1'b1;
      if (hit_inc && (hit_q != '1)) hit_q <= hit_q + 1'b1;
      if (miss_inc && (miss_q != '1)) miss_q <= miss_q + 1'b1;
    end
  end

  // Tag/data storage has no reset; a reset aborts any pending update.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (fill) begin
        tag_q[m_idx]  <= m_tag;
        data_q[m_idx] <= mem_rdata;
      end else if (wupd) begin
        data_q[m_idx] <= wdata_q;
      end
    end
  end

endmodule
